// File: rtl/conv_encoder_sequencer.sv
// Frame controller for the 802.11a rate-1/2 K=7 convolutional encoder: paces data bits,
// appends the zero tail, and punctures the serial coded stream to 1/2, 2/3 or 3/4.
module conv_encoder_sequencer #(
  parameter int LEN_W     = 16,
  parameter int TAIL_BITS = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Rate,
  input  logic [LEN_W-1:0] NumBits,
  input  logic             InData,
  input  logic             InValid,
  output logic             InReady,
  output logic             EncInput,
  output logic             EncClear,
  input  logic             EncOutput,
  output logic             OutData,
  output logic             OutValid,
  output logic             Busy,
  output logic             Done,
  output logic             Error
);

  localparam int TAIL_W = $clog2(TAIL_BITS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DATA, TAIL} state_t;

  state_t             state_q, state_d;
  logic               phase_q, phase_d;
  logic [1:0]         rate_q, rate_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [1:0]         pi_q, pi_d;
  logic [TAIL_W-1:0]  tail_q, tail_d;
  logic               cur_bit_q, cur_bit_d;
  logic               enc_clear_q, enc_clear_d;
  logic               out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  // Whether the coded bit at (pattern position, phase) survives puncturing.
  function automatic logic keep_bit(input logic [1:0] rate, input logic [1:0] pi,
                                    input logic phase);
    logic k;
    case (rate)
      2'b01:   k = (pi == 2'd0) || !phase;
      2'b10:   k = (pi == 2'd0) || ((pi == 2'd1) && !phase) || ((pi == 2'd2) && phase);
      default: k = 1'b1;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] next_pi(input logic [1:0] rate, input logic [1:0] pi);
    logic [1:0] nxt;
    case (rate)
      2'b01:   nxt = (pi == 2'd0) ? 2'd1 : 2'd0;
      2'b10:   nxt = (pi == 2'd2) ? 2'd0 : pi + 2'd1;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    remaining_d = remaining_q;
    pi_d        = pi_q;
    tail_d      = tail_q;
    cur_bit_d   = cur_bit_q;
    error_d     = 1'b0;
    done_d      = 1'b0;
    out_valid_d = 1'b0;
    InReady     = 1'b0;
    EncInput    = 1'b0;
    // Phase tracks the encoder: held at 0 while it is cleared, toggling once running.
    phase_d     = (state_q == DATA || state_q == TAIL) ? ~phase_q : 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          rate_d      = Rate;
          remaining_d = NumBits;
          pi_d        = 2'd0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (remaining_q == '0) begin
          tail_d  = TAIL_W'(TAIL_BITS);
          state_d = TAIL;
        end else begin
          InReady = 1'b1;
          if (InValid) begin
            cur_bit_d   = InData;
            remaining_d = remaining_q - LEN_W'(1);
            state_d     = DATA;
          end
        end
      end
      DATA: begin
        EncInput    = cur_bit_q;
        out_valid_d = keep_bit(rate_q, pi_q, phase_q);
        if (phase_q) begin
          pi_d = next_pi(rate_q, pi_q);
          if (remaining_q == '0) begin
            tail_d  = TAIL_W'(TAIL_BITS);
            state_d = TAIL;
          end else begin
            InReady = 1'b1;
            if (InValid) begin
              cur_bit_d   = InData;
              remaining_d = remaining_q - LEN_W'(1);
            end else begin
              error_d = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      TAIL: begin
        out_valid_d = keep_bit(rate_q, pi_q, phase_q);
        if (phase_q) begin
          pi_d = next_pi(rate_q, pi_q);
          if (tail_q == TAIL_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tail_d = tail_q - TAIL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    enc_clear_d = (state_d == IDLE) || (state_d == LOAD);
    busy_d      = (state_d != IDLE) || done_d;
    out_data_d  = EncOutput;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      enc_clear_q <= 1'b1;
      out_data_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      enc_clear_q <= enc_clear_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // Frame parameters and counters are always reloaded before use, so they carry no reset.
  always_ff @(posedge Clock) begin
    rate_q      <= rate_d;
    remaining_q <= remaining_d;
    pi_q        <= pi_d;
    tail_q      <= tail_d;
    cur_bit_q   <= cur_bit_d;
  end

  assign EncClear = enc_clear_q;
  assign OutData  = out_data_q;
  assign OutValid = out_valid_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Error    = error_q;

endmodule

// File: tb/tb_conv_encoder_sequencer.sv
// Scoreboard bench for conv_encoder_sequencer with a behavioural K=7 encoder alongside.
module tb_conv_encoder_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Rate;
  logic [15:0] NumBits;
  logic        InData;
  logic        InValid;
  logic        InReady;
  logic        EncInput;
  logic        EncClear;
  logic        EncOutput;
  logic        OutData;
  logic        OutValid;
  logic        Busy;
  logic        Done;
  logic        Error;

  always #5 Clock = ~Clock;

  conv_encoder_sequencer #(.LEN_W(16), .TAIL_BITS(6)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Rate(Rate), .NumBits(NumBits),
    .InData(InData), .InValid(InValid), .InReady(InReady), .EncInput(EncInput),
    .EncClear(EncClear), .EncOutput(EncOutput), .OutData(OutData), .OutValid(OutValid),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  // Encoder: A in phase 0, B in phase 1, shift at end of phase 1; sr[0] is the newest bit.
  logic [5:0] enc_sr;
  logic       enc_ph;
  logic       enc_a, enc_b;
  always_ff @(posedge Clock) begin
    if (EncClear) begin
      enc_sr <= '0;
      enc_ph <= 1'b0;
    end else begin
      enc_ph <= ~enc_ph;
      if (enc_ph) enc_sr <= {enc_sr[4:0], EncInput};
    end
  end
  assign enc_a     = EncInput ^ enc_sr[1] ^ enc_sr[2] ^ enc_sr[4] ^ enc_sr[5];
  assign enc_b     = EncInput ^ enc_sr[0] ^ enc_sr[1] ^ enc_sr[2] ^ enc_sr[5];
  assign EncOutput = enc_ph ? enc_b : enc_a;

  int   tests = 0;
  int   fails = 0;
  int   out_cnt, ones_cnt, busy_cnt, ready_cnt, done_cnt, err_cnt;
  logic exp_q[$];
  logic frame_bits [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_encclear"}, 32'(EncClear), 1);
    check({tag, "_inready"},  32'(InReady),  0);
    check({tag, "_encinput"}, 32'(EncInput), 0);
    check({tag, "_outdata"},  32'(OutData),  0);
    check({tag, "_outvalid"}, 32'(OutValid), 0);
    check({tag, "_busy"},     32'(Busy),     0);
    check({tag, "_done"},     32'(Done),     0);
    check({tag, "_error"},    32'(Error),    0);
  endtask

  task automatic set_bits(input logic [15:0] v);
    for (int i = 0; i < 16; i++) frame_bits[i] = v[i];
  endtask

  // Reference: generator polynomials 133/171 octal, puncture masks over (A0 B0 A1 B1 A2 B2).
  task automatic push_model(input logic [1:0] rate, input int n, input bit with_tail);
    logic [5:0] sr;
    logic [6:0] win;
    logic [0:3] k23;
    logic [0:5] k34;
    logic       u, a, b, ka, kb;
    int         np, m;
    k23 = 4'b1110;
    k34 = 6'b111001;
    sr  = '0;
    np  = n + (with_tail ? 6 : 0);
    for (int p = 0; p < np; p++) begin
      u   = (p < n) ? frame_bits[p] : 1'b0;
      win = {u, sr[0], sr[1], sr[2], sr[3], sr[4], sr[5]};
      a   = ^(win & 7'o133);
      b   = ^(win & 7'o171);
      case (rate)
        2'b01: begin m = p % 2; ka = k23[2*m]; kb = k23[2*m+1]; end
        2'b10: begin m = p % 3; ka = k34[2*m]; kb = k34[2*m+1]; end
        default: begin ka = 1'b1; kb = 1'b1; end
      endcase
      if (ka) exp_q.push_back(a);
      if (kb) exp_q.push_back(b);
      sr = {sr[4:0], u};
    end
  endtask

  task automatic run_frame(input logic [1:0] rate, input int n, input int drop,
                           input bit glitch, input int abort_at);
    int idx = 0;
    int np  = n + 6;
    bit aborted = 0;
    out_cnt = 0; ones_cnt = 0; busy_cnt = 0; ready_cnt = 0; done_cnt = 0; err_cnt = 0;
    @(negedge Clock); #1;
    Start = 1'b1; Rate = rate; NumBits = 16'(n); InValid = 1'b0;
    @(negedge Clock); #1;
    Start = 1'b0;
    for (int c = 0; c < 2*np + 12; c++) begin
      InData  = frame_bits[idx];
      InValid = (idx < n) && (idx != drop);
      Start   = glitch && (c == 6);
      Rate    = (glitch && c == 6) ? 2'b00 : rate;
      NumBits = (glitch && c == 6) ? 16'd3 : 16'(n);
      if (c == abort_at) begin
        #1 Reset = 1'b1;
        #1 check_reset_vals("abort");
        exp_q.delete();
        aborted = 1;
        break;
      end
      #1;
      if (InValid && InReady) idx++;
      @(negedge Clock); #1;
    end
    InValid = 1'b0;
    Start   = 1'b0;
    if (aborted) begin
      @(negedge Clock); #1 Reset = 1'b0;
      repeat (4) @(negedge Clock);
      check("abort_no_done",  32'(done_cnt), 0);
      check("abort_no_error", 32'(err_cnt),  0);
    end else begin
      check("queue_drained", 32'(exp_q.size()), 0);
      if (drop < 0) begin
        check("done_count",  32'(done_cnt),  1);
        check("error_count", 32'(err_cnt),   0);
        check("busy_cycles", 32'(busy_cnt),  32'(2*np + 2));
        check("ready_cycles", 32'(ready_cnt), 32'(n));
      end else begin
        check("underrun_error", 32'(err_cnt),  1);
        check("underrun_done",  32'(done_cnt), 0);
        check("underrun_clear", 32'(EncClear), 1);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every OutValid and checks Done/Error context.
  initial begin
    logic e;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        if (Busy) busy_cnt++;
        if (InReady) ready_cnt++;
        if (OutValid) begin
          out_cnt++;
          ones_cnt += int'(OutData);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL out_extra: OutValid=1 with OutData=%0d, expected no output", OutData);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 32'(OutData), 32'(e));
          end
        end
        if (Done) begin
          done_cnt++;
          check("done_with_last", 32'(exp_q.size()), 0);
        end
        if (Error) begin
          err_cnt++;
          check("error_encclear", 32'(EncClear), 1);
          check("error_busy", 32'(Busy), 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:13] hand;
    Reset = 1'b1; Start = 1'b0; Rate = 2'b00; NumBits = '0; InData = 1'b0; InValid = 1'b0;
    #1 check_reset_vals("reset");
    repeat (3) @(negedge Clock);
    #1 Reset = 1'b0;

    // Rate 1/2, single 1: hand-derived impulse response of the 133/171 code.
    set_bits(16'h0001);
    hand = 14'b11011111001011;
    for (int i = 0; i < 14; i++) exp_q.push_back(hand[i]);
    run_frame(2'b00, 1, -1, 0, -1);
    check("t1_count", 32'(out_cnt), 14);
    check("t1_ones", 32'(ones_cnt), 10);

    // Tail only.
    for (int i = 0; i < 12; i++) exp_q.push_back(1'b0);
    run_frame(2'b00, 0, -1, 0, -1);
    check("t2_count", 32'(out_cnt), 12);

    set_bits(16'h0001);
    push_model(2'b01, 2, 1);
    run_frame(2'b01, 2, -1, 0, -1);
    check("t3_count", 32'(out_cnt), 12);

    set_bits(16'h002D);
    push_model(2'b10, 6, 1);
    run_frame(2'b10, 6, -1, 1, -1);
    check("t4_count", 32'(out_cnt), 16);

    // Underrun at the fourth phase-1 request: pairs 0..3 are emitted, nothing after.
    set_bits(16'h00B5);
    push_model(2'b00, 4, 0);
    run_frame(2'b00, 8, 4, 0, -1);
    check("t5_count", 32'(out_cnt), 8);

    set_bits(16'h0006);
    push_model(2'b00, 3, 1);
    run_frame(2'b00, 3, -1, 0, -1);

    set_bits(16'h00A7);
    push_model(2'b00, 8, 1);
    run_frame(2'b00, 8, -1, 0, 5);

    // Rate 3/4 with 11 pairs ends on a partial pattern.
    set_bits(16'h0019);
    push_model(2'b10, 5, 1);
    run_frame(2'b10, 5, -1, 0, -1);
    check("t8_count", 32'(out_cnt), 15);

    set_bits(16'h0003);
    push_model(2'b11, 2, 1);
    run_frame(2'b11, 2, -1, 0, -1);
    check("t9_count", 32'(out_cnt), 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
